// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the single-port Data_Memory between the CPU MEM stage and a DMA port
// CPU has priority; a starvation counter and a burst cap bound each side's wait.
module data_mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic [WIDTH-1:0] cpu_rd,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [WIDTH-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wd,
  output logic [WIDTH-1:0] dma_rd,
  output logic             dma_gnt,
  output logic [WIDTH-1:0] mem_A,
  output logic [WIDTH-1:0] mem_WD,
  output logic             mem_WE,
  input  logic [WIDTH-1:0] mem_RD
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_CAP  = BW'(MAX_BURST);
  localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'b00, CPU = 2'b01, DMA = 2'b10} owner_t;

  owner_t        owner, owner_next;
  logic [BW-1:0] burst_cnt, burst_next;
  logic [SW-1:0] starve_cnt, starve_next;
  logic          cpu_gnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner      <= IDLE;
      burst_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      owner      <= owner_next;
      burst_cnt  <= burst_next;
      starve_cnt <= starve_next;
    end
  end

  // Grant decision: a running DMA burst keeps the port until capped, then the CPU
  // wins unless the DMA has been starved long enough to override it.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!RST) begin
      if (owner == DMA && dma_req && burst_cnt < BURST_CAP) dma_gnt = 1'b1;
      else if (cpu_req && starve_cnt < STARVE_CAP)          cpu_gnt = 1'b1;
      else if (dma_req)                                     dma_gnt = 1'b1;
      else if (cpu_req)                                     cpu_gnt = 1'b1;
    end
    owner_next = dma_gnt ? DMA : (cpu_gnt ? CPU : IDLE);
    burst_next = '0;
    if (dma_gnt)
      burst_next = (burst_cnt == BURST_CAP) ? burst_cnt : burst_cnt + BW'(1);
    starve_next = '0;
    if (dma_req && !dma_gnt)
      starve_next = (starve_cnt == STARVE_CAP) ? starve_cnt : starve_cnt + SW'(1);
  end

  always_comb begin
    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 1'b0;
    cpu_rd = '0;
    dma_rd = '0;
    if (cpu_gnt) begin
      mem_A  = cpu_addr;
      mem_WD = cpu_wd;
      mem_WE = cpu_we;
      cpu_rd = mem_RD;
    end else if (dma_gnt) begin
      mem_A  = dma_addr;
      mem_WD = dma_wd;
      mem_WE = dma_we;
      dma_rd = mem_RD;
    end
    cpu_stall = cpu_req & ~cpu_gnt;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
// Inputs change on the falling edge and outputs are compared 1 ns later.
module tb_data_mem_arbiter;

  localparam int W  = 32;
  localparam int SL = 4;
  localparam int MB = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         cpu_req, cpu_we, dma_req, dma_we;
  logic [W-1:0] cpu_addr, cpu_wd, dma_addr, dma_wd;
  logic [W-1:0] cpu_rd, dma_rd, mem_A, mem_WD, mem_RD;
  logic         cpu_stall, dma_gnt, mem_WE;

  logic [W-1:0] mem     [0:63];
  logic [W-1:0] ref_mem [0:63];

  int checks = 0;
  int errors = 0;

  // reference model state
  bit           m_dma_owner;
  int           m_burst, m_starve;
  bit           exp_gc, exp_gd, exp_stall, exp_we;
  logic [W-1:0] exp_a, exp_wd, exp_cpu_rd, exp_dma_rd;

  data_mem_arbiter #(.WIDTH(W), .STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_rd(dma_rd), .dma_gnt(dma_gnt),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always #5 CLK = ~CLK;

  assign mem_RD = mem[mem_A[5:0]];
  always @(posedge CLK) if (mem_WE) mem[mem_A[5:0]] <= mem_WD;

  task automatic apply(input logic rst, input logic cr, input logic cw, input logic [W-1:0] ca,
                       input logic [W-1:0] cwd, input logic dr, input logic dw,
                       input logic [W-1:0] da, input logic [W-1:0] dwd);
    @(negedge CLK);
    RST = rst; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wd = cwd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wd = dwd;
    #1;
    exp_gc = 0; exp_gd = 0;
    if (!rst) begin
      if (m_dma_owner && dr && m_burst < MB) exp_gd = 1;
      else if (cr && m_starve < SL)          exp_gc = 1;
      else if (dr)                           exp_gd = 1;
      else if (cr)                           exp_gc = 1;
    end
    exp_stall  = cr && !exp_gc;
    exp_we     = (exp_gc && cw) || (exp_gd && dw);
    exp_a      = exp_gc ? ca : (exp_gd ? da : '0);
    exp_wd     = exp_gc ? cwd : (exp_gd ? dwd : '0);
    exp_cpu_rd = exp_gc ? ref_mem[ca[5:0]] : '0;
    exp_dma_rd = exp_gd ? ref_mem[da[5:0]] : '0;
  endtask

  task automatic advance();
    @(posedge CLK);
    if (RST) begin
      m_dma_owner = 0; m_burst = 0; m_starve = 0;
    end else begin
      if (exp_gc && cpu_we) ref_mem[cpu_addr[5:0]] = cpu_wd;
      if (exp_gd && dma_we) ref_mem[dma_addr[5:0]] = dma_wd;
      m_dma_owner = exp_gd;
      m_burst  = exp_gd ? ((m_burst + 1 > MB) ? MB : m_burst + 1) : 0;
      m_starve = (dma_req && !exp_gd) ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
    end
  endtask

  task automatic idle();
    apply(0, 0, 0, '0, '0, 0, 0, '0, '0);
    advance();
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 32'd3, 32'h1111, 1, 1, 32'd4, 32'h2222);
    checks++;
    if ({mem_WE, dma_gnt, cpu_stall} !== 3'b001 || cpu_rd !== '0 || dma_rd !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we/gnt/stall=%b%b%b cpu_rd=%h dma_rd=%h, want 001 0 0",
               mem_WE, dma_gnt, cpu_stall, cpu_rd, dma_rd);
    end
    advance();
    apply(0, 1, 1, 32'd3, 32'h1111, 1, 1, 32'd4, 32'h2222);
    checks++;
    if ({dma_gnt, cpu_stall, mem_WE} !== 3'b001 || mem_A !== 32'd3) begin
      errors++;
      $display("FAIL reset_release_cpu_first: gnt/stall/we=%b%b%b A=%h, want 001 A=3",
               dma_gnt, cpu_stall, mem_WE, mem_A);
    end
    advance();
  endtask

  task automatic test_cpu_only();
    apply(0, 1, 1, 32'd8, 32'hDEADBEEF, 0, 0, '0, '0);
    checks++;
    if ({mem_WE, cpu_stall} !== 2'b10 || mem_A !== 32'd8 || mem_WD !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL cpu_sw: we=%b stall=%b A=%h WD=%h, want 1 0 8 deadbeef",
               mem_WE, cpu_stall, mem_A, mem_WD);
    end
    advance();
    apply(0, 1, 0, 32'd8, '0, 0, 0, '0, '0);
    checks++;
    if (cpu_rd !== 32'hDEADBEEF || cpu_stall !== 1'b0 || mem_WE !== 1'b0) begin
      errors++;
      $display("FAIL cpu_lw: rd=%h stall=%b we=%b, want deadbeef 0 0", cpu_rd, cpu_stall, mem_WE);
    end
    advance();
  endtask

  task automatic test_alternation();
    idle();
    for (int c = 0; c < 16; c++) begin
      bit d;
      d = (c % 8) >= 4;
      apply(0, 1, 0, 32'd1, '0, 1, 0, 32'd2, '0);
      checks++;
      if ({dma_gnt, cpu_stall} !== {d, d} || mem_A !== (d ? 32'd2 : 32'd1)) begin
        errors++;
        $display("FAIL alternation cyc %0d: gnt=%b stall=%b A=%h, want gnt=%b stall=%b",
                 c, dma_gnt, cpu_stall, mem_A, d, d);
      end
      advance();
    end
  endtask

  task automatic test_dma_stream();
    idle();
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a;
      a = W'(i % 10);
      apply(0, 0, 0, '0, '0, 1, i < 10, a, a + 1);
      checks++;
      if (dma_gnt !== 1'b1 || (i >= 10 && dma_rd !== a + 1)) begin
        errors++;
        $display("FAIL dma_stream cyc %0d: gnt=%b rd=%h, want gnt=1 rd=%h", i, dma_gnt, dma_rd, a + 1);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_burst();
    idle();
    for (int c = 0; c < 6; c++) begin
      apply(0, 1, 1, 32'd40, 32'hC0DE, 1, 1, 32'd41, W'(c));
      advance();
    end
    apply(1, 1, 1, 32'd40, 32'hC0DE, 1, 1, 32'd41, 32'hBAD);
    checks++;
    if ({mem_WE, dma_gnt, cpu_stall} !== 3'b001 || dma_rd !== '0) begin
      errors++;
      $display("FAIL reset_mid_burst: we/gnt/stall=%b%b%b dma_rd=%h, want 001 0",
               mem_WE, dma_gnt, cpu_stall, dma_rd);
    end
    advance();
    for (int c = 0; c < 8; c++) begin
      bit d;
      d = c >= 4;
      apply(0, 1, 0, 32'd40, '0, 1, 0, 32'd41, '0);
      checks++;
      if ({dma_gnt, cpu_stall} !== {d, d}) begin
        errors++;
        $display("FAIL after_reset cyc %0d: gnt=%b stall=%b, want %b", c, dma_gnt, cpu_stall, d);
      end
      advance();
    end
  endtask

  task automatic test_starve_clear();
    idle();
    for (int c = 0; c < 8; c++) begin
      apply(0, 1, 0, 32'd5, '0, c != 2, 0, 32'd6, '0);
      checks++;
      if (dma_gnt !== (c == 7)) begin
        errors++;
        $display("FAIL starve_clear cyc %0d: gnt=%b want %b", c, dma_gnt, c == 7);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic         cr = 0, cw = 0, dr = 0, dw = 0, rst;
    logic [W-1:0] ca = '0, cwd = '0, da = '0, dwd = '0;
    bit           c_pend = 0, d_pend = 0;
    int           cs_run = 0, dw_run = 0, max_cs = 0, max_dw = 0;
    idle();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!c_pend) begin
        cr = $urandom_range(0, 3) != 0; cw = $urandom_range(0, 1) != 0;
        ca = W'($urandom_range(0, 15)); cwd = $urandom;
      end
      if (!d_pend) begin
        dr = $urandom_range(0, 2) != 0; dw = $urandom_range(0, 1) != 0;
        da = W'($urandom_range(0, 15)); dwd = $urandom;
      end
      apply(rst, cr, cw, ca, cwd, dr, dw, da, dwd);
      checks++;
      if ({dma_gnt, cpu_stall, mem_WE, mem_A, mem_WD, cpu_rd, dma_rd} !==
          {exp_gd, exp_stall, exp_we, exp_a, exp_wd, exp_cpu_rd, exp_dma_rd}) begin
        errors++;
        $display("FAIL random cyc %0d: gnt/stall/we=%b%b%b A=%h WD=%h crd=%h drd=%h, want %b%b%b %h %h %h %h",
                 i, dma_gnt, cpu_stall, mem_WE, mem_A, mem_WD, cpu_rd, dma_rd,
                 exp_gd, exp_stall, exp_we, exp_a, exp_wd, exp_cpu_rd, exp_dma_rd);
      end
      c_pend = cr && !dma_gnt && !cpu_stall ? 0 : (cr && cpu_stall);
      d_pend = dr && !dma_gnt;
      if (rst) begin
        cs_run = 0; dw_run = 0;
      end else begin
        cs_run = cpu_stall ? cs_run + 1 : 0;
        dw_run = (dr && !dma_gnt) ? dw_run + 1 : 0;
        if (cs_run > max_cs) max_cs = cs_run;
        if (dw_run > max_dw) max_dw = dw_run;
      end
      advance();
    end
    checks++;
    if (max_cs > MB) begin
      errors++;
      $display("FAIL cpu_stall_bound: longest stall %0d, limit %0d", max_cs, MB);
    end
    checks++;
    if (max_dw > SL) begin
      errors++;
      $display("FAIL dma_wait_bound: longest wait %0d, limit %0d", max_dw, SL);
    end
  endtask

  initial begin
    RST = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wd = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wd = '0;
    m_dma_owner = 0; m_burst = 0; m_starve = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(posedge CLK);
    test_reset();
    test_cpu_only();
    test_alternation();
    test_dma_stream();
    test_reset_mid_burst();
    test_starve_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
